wishbone_master: RTL

Single-outstanding Wishbone classic-cycle initiator that turns a simple valid/ready command port into bus transactions toward the 4-bit-address, 32-bit register-block slave. It sits between the host-side control logic and the register-block slave: it drives cyc/stb/we/adr/dat_mosi, waits for ack, and returns read data or an error on a one-cycle response strobe. An optional watchdog aborts cycles the slave never acknowledges, for example after the slave has latched its communication-halt state.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wbm_timeout_ctr.sv | 28 ++
 rtl/wishbone_master.sv | 122 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the 4-bit-address, 32-bit register-block bus.
package wb_pkg;

  localparam int unsigned WB_ADR_W = 4;
  localparam int unsigned WB_DAT_W = 32;
  localparam logic [31:0] WB_HALT_PATTERN = 32'hCAFEBABE;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RECOVER
  } wbm_state_t;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th consecutive enabled cycle is in progress.
module wbm_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // The edge that would bring the count to LIMIT is the abort edge.
  assign o_expired = i_enable && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone classic-cycle initiator with valid/ready command
// port. Define WBM_TIMEOUT_EN to build the no-ack watchdog (TIMEOUT_CYCLES).
module wishbone_master
  import wb_pkg::*;
#(
  parameter int unsigned ADR_W          = WB_ADR_W,
  parameter int unsigned DAT_W          = WB_DAT_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [DAT_W-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [DAT_W-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             cyc,
  output logic             stb,
  output logic             we,
  output logic [ADR_W-1:0] adr,
  output logic [DAT_W-1:0] dat_mosi,
  input  logic [DAT_W-1:0] dat_miso,
  input  logic             ack
);

  wbm_state_t       r_state;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [DAT_W-1:0] r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_cyc;
  logic             r_stb;
  logic             r_we;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_dat_mosi;

  logic w_accept;
  logic w_timeout;

  assign w_accept = req_valid && r_req_ready;

`ifdef WBM_TIMEOUT_EN
  wbm_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_accept),
    .i_enable ((r_state == BUS) && !ack),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Reset lands in RECOVER so the first edge after release raises req_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RECOVER;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat_mosi  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= BUS;
            r_req_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_we        <= req_we;
            r_adr       <= req_adr;
            r_dat_mosi  <= req_wdata;
          end
        end
        BUS: begin
          // Ack has priority over a watchdog expiry on the same edge.
          if (ack || w_timeout) begin
            r_state     <= RECOVER;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat_mosi  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !ack;
            r_rsp_rdata <= ack ? dat_miso : '0;
          end
        end
        RECOVER: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_err   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign cyc       = r_cyc;
  assign stb       = r_stb;
  assign we        = r_we;
  assign adr       = r_adr;
  assign dat_mosi  = r_dat_mosi;

endmodule
